// File: rtl/scarv_ccx_pkg.sv
// Shared types for the CCX memory-interface arbiter: requester select encoding.
package scarv_ccx_pkg;

  typedef logic memif_sel_t;

  localparam memif_sel_t SEL_M0 = 1'b0;
  localparam memif_sel_t SEL_M1 = 1'b1;

endpackage

// File: rtl/scarv_ccx_memif.sv
// Request/grant memory interface. A requester holds req and its payload until
// gnt; rdata/error come back one cycle after the accepting cycle.
interface scarv_ccx_memif #(
  parameter int AW = 32,
  parameter int DW = 32
) ();

  logic            req;
  logic            gnt;
  logic            wen;
  logic [DW/8-1:0] strb;
  logic [DW-1:0]   wdata;
  logic [DW-1:0]   rdata;
  logic [AW-1:0]   addr;
  logic            error;

  // Requester side drives the request, responder side drives grant/response.
  modport REQ (output req, wen, strb, wdata, addr, input gnt, rdata, error);
  modport RSP (input req, wen, strb, wdata, addr, output gnt, rdata, error);

endinterface

// File: rtl/scarv_ccx_rr_arb2.sv
// Two-way requester select: a locked (presented, not yet granted) request keeps
// the port; otherwise a lone requester wins and ties go by priority mode.
module scarv_ccx_rr_arb2
  import scarv_ccx_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic [1:0] req,
  input  logic       lock,
  input  memif_sel_t lock_sel,
  input  memif_sel_t last,
  output memif_sel_t sel
);

  // Pick the requester to forward; idle parks on the last winner.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    sel = last;
    if (lock && req[lock_sel]) begin
      // A locked requester that dropped req loses the lock immediately.
      sel = lock_sel;
    end else begin
      unique case (req)
        2'b01:   sel = SEL_M0;
        2'b10:   sel = SEL_M1;
        2'b11:   sel = FIXED_PRIO ? SEL_M0 : ~last;
        default: sel = last;
      endcase
    end
  end

endmodule

// File: rtl/scarv_ccx_memif_arb.sv
// 2:1 arbiter merging the instruction (m0) and data (m1) memory ports onto a
// single CCX memory port. Request and grant pass through combinationally;
// responses are steered back to the requester accepted in the previous cycle.
module scarv_ccx_memif_arb
  import scarv_ccx_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  scarv_ccx_memif.RSP     m0,
  scarv_ccx_memif.RSP     m1,
  scarv_ccx_memif.REQ     s
);

  logic       lock_q, lock_d;
  memif_sel_t lock_sel_q, lock_sel_d;
  memif_sel_t last_q, last_d;
  logic       rsp_v_q, rsp_v_d;
  memif_sel_t rsp_sel_q, rsp_sel_d;

  memif_sel_t      sel;
  logic            fwd_req;
  logic            fwd_wen;
  logic [DW/8-1:0] fwd_strb;
  logic [DW-1:0]   fwd_wdata;
  logic [AW-1:0]   fwd_addr;
  logic            s_req;
  logic            accept;

  scarv_ccx_rr_arb2 #(
    .FIXED_PRIO (FIXED_PRIO != 0)
  ) u_sel (
    .req      ({m1.req, m0.req}),
    .lock     (lock_q),
    .lock_sel (lock_sel_q),
    .last     (last_q),
    .sel      (sel)
  );

  // Mux the selected requester's payload onto the shared port.
  always_comb begin
    fwd_req   = m0.req;
    fwd_wen   = m0.wen;
    fwd_strb  = m0.strb;
    fwd_wdata = m0.wdata;
    fwd_addr  = m0.addr;
    if (sel == SEL_M1) begin
      fwd_req   = m1.req;
      fwd_wen   = m1.wen;
      fwd_strb  = m1.strb;
      fwd_wdata = m1.wdata;
      fwd_addr  = m1.addr;
    end
    s_req  = g_resetn && fwd_req;
    accept = s_req && s.gnt;
  end

  assign s.req   = s_req;
  assign s.wen   = fwd_wen;
  assign s.strb  = fwd_strb;
  assign s.wdata = fwd_wdata;
  assign s.addr  = fwd_addr;

  // Grant only the selected requester; responses go back to the latched owner.
  assign m0.gnt   = g_resetn && s.gnt && (sel == SEL_M0);
  assign m1.gnt   = g_resetn && s.gnt && (sel == SEL_M1);
  assign m0.rdata = s.rdata;
  assign m1.rdata = s.rdata;
  assign m0.error = g_resetn && s.error && rsp_v_q && (rsp_sel_q == SEL_M0);
  assign m1.error = g_resetn && s.error && rsp_v_q && (rsp_sel_q == SEL_M1);

  // Next state: lock onto a stalled request, record winner and response owner.
  always_comb begin
    lock_d     = 1'b0;
    lock_sel_d = lock_sel_q;
    last_d     = last_q;
    rsp_v_d    = accept;
    rsp_sel_d  = sel;
    if (s_req && !s.gnt) begin
      lock_d     = 1'b1;
      lock_sel_d = sel;
    end else if (accept) begin
      last_d = sel;
    end
  end

  // State register with synchronous reset; last=1 lets m0 win the first tie.
  always_ff @(posedge g_clk) begin
    // NOTE: reset is sampled on the clock edge only, so it sits inside the
    // edge-triggered block rather than in the sensitivity list.
    if (!g_resetn) begin
      lock_q     <= 1'b0;
      lock_sel_q <= SEL_M0;
      last_q     <= SEL_M1;
      rsp_v_q    <= 1'b0;
      rsp_sel_q  <= SEL_M0;
    end else begin
      // NOTE: non-blocking assignments keep every flop updating from the
      // values present before the edge.
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
      last_q     <= last_d;
      rsp_v_q    <= rsp_v_d;
      rsp_sel_q  <= rsp_sel_d;
    end
  end

endmodule

// File: tb/tb_scarv_ccx_memif_arb.sv
// Bench for the 2:1 CCX memory arbiter: directed scenarios with literal
// expectations, then random traffic checked every cycle by a reference model.
module tb_scarv_ccx_memif_arb;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  scarv_ccx_memif #(.AW(32), .DW(32)) m0_if ();
  scarv_ccx_memif #(.AW(32), .DW(32)) m1_if ();
  scarv_ccx_memif #(.AW(32), .DW(32)) s_if ();
  scarv_ccx_memif #(.AW(32), .DW(32)) p0_if ();
  scarv_ccx_memif #(.AW(32), .DW(32)) p1_if ();
  scarv_ccx_memif #(.AW(32), .DW(32)) ps_if ();

  scarv_ccx_memif_arb #(.AW(32), .DW(32), .FIXED_PRIO(0)) dut (
    .g_clk(clk), .g_resetn(resetn), .m0(m0_if), .m1(m1_if), .s(s_if)
  );

  scarv_ccx_memif_arb #(.AW(32), .DW(32), .FIXED_PRIO(1)) dut_fp (
    .g_clk(clk), .g_resetn(resetn), .m0(p0_if), .m1(p1_if), .s(ps_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model (round-robin DUT) ----------------
  // own   : master whose request was shown to the fabric but not yet granted
  // lastw : master that won the most recent accept
  // rspto : master whose response returns this cycle
  int own   = -1;
  int lastw = 1;
  int rspto = -1;
  int waits [2] = '{0, 0};

  function automatic int pick(input bit r0, input bit r1);
    if (own == 0 && r0) return 0;
    if (own == 1 && r1) return 1;
    if (r0 && r1) return 1 - lastw;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  always @(negedge clk) begin
    int  c;
    bit  r0, r1, a0, a1;
    r0 = m0_if.req;
    r1 = m1_if.req;
    c  = pick(r0, r1);
    if (!resetn) begin
      check("mdl_rst_sreq", s_if.req, 0);
      check("mdl_rst_gnt0", m0_if.gnt, 0);
      check("mdl_rst_gnt1", m1_if.gnt, 0);
      check("mdl_rst_err0", m0_if.error, 0);
      check("mdl_rst_err1", m1_if.error, 0);
      own = -1; lastw = 1; rspto = -1; waits[0] = 0; waits[1] = 0;
    end else begin
      check("mdl_sreq", s_if.req, (c >= 0) ? 1 : 0);
      if (c == 0) begin
        check("mdl_addr0", s_if.addr, m0_if.addr);
        check("mdl_wdata0", s_if.wdata, m0_if.wdata);
        check("mdl_wen0", s_if.wen, m0_if.wen);
        check("mdl_strb0", s_if.strb, m0_if.strb);
      end else if (c == 1) begin
        check("mdl_addr1", s_if.addr, m1_if.addr);
        check("mdl_wdata1", s_if.wdata, m1_if.wdata);
        check("mdl_wen1", s_if.wen, m1_if.wen);
        check("mdl_strb1", s_if.strb, m1_if.strb);
      end
      if (r0) check("mdl_gnt0", m0_if.gnt, (c == 0 && s_if.gnt) ? 1 : 0);
      if (r1) check("mdl_gnt1", m1_if.gnt, (c == 1 && s_if.gnt) ? 1 : 0);
      check("mdl_err0", m0_if.error, (s_if.error && rspto == 0) ? 1 : 0);
      check("mdl_err1", m1_if.error, (s_if.error && rspto == 1) ? 1 : 0);
      // Starvation bound, measured on accepts actually observed at the DUT.
      a0 = m0_if.req && m0_if.gnt;
      a1 = m1_if.req && m1_if.gnt;
      if (!r0) waits[0] = 0;
      if (!r1) waits[1] = 0;
      if (a0) begin
        waits[0] = 0;
        if (r1) begin waits[1]++; check("mdl_wait1_le2", (waits[1] <= 2) ? 1 : 0, 1); end
      end
      if (a1) begin
        waits[1] = 0;
        if (r0) begin waits[0]++; check("mdl_wait0_le2", (waits[0] <= 2) ? 1 : 0, 1); end
      end
      // Advance model to the next cycle.
      if (c >= 0 && s_if.gnt) begin
        rspto = c; lastw = c; own = -1;
      end else begin
        rspto = -1; own = c;
      end
    end
    check("mdl_rdata0", m0_if.rdata, s_if.rdata);
    check("mdl_rdata1", m1_if.rdata, s_if.rdata);
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_m(input int x, input bit r, input logic [31:0] a,
                       input logic [31:0] wd, input bit w, input logic [3:0] st);
    if (x == 0) begin
      m0_if.req = r; m0_if.addr = a; m0_if.wdata = wd; m0_if.wen = w; m0_if.strb = st;
    end else begin
      m1_if.req = r; m1_if.addr = a; m1_if.wdata = wd; m1_if.wen = w; m1_if.strb = st;
    end
  endtask

  task automatic set_s(input bit g, input logic [31:0] rd, input bit e);
    s_if.gnt = g; s_if.rdata = rd; s_if.error = e;
  endtask

  task automatic do_reset(input int n);
    resetn = 1'b0;
    repeat (n) cyc();
    resetn = 1'b1;
  endtask

  initial begin
    bit acc [2];
    set_m(0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0);
    set_s(0, 0, 0);
    p0_if.req = 0; p0_if.addr = 0; p0_if.wdata = 0; p0_if.wen = 0; p0_if.strb = 0;
    p1_if.req = 0; p1_if.addr = 0; p1_if.wdata = 0; p1_if.wen = 0; p1_if.strb = 0;
    ps_if.gnt = 0; ps_if.rdata = 0; ps_if.error = 0;

    // Reset state: outputs held quiet even with a request and grant present.
    cyc();
    set_m(0, 1, 32'h1000, 0, 0, 4'hF);
    set_s(1, 0, 1);
    smp();
    check("rst_sreq", s_if.req, 0);
    check("rst_gnt0", m0_if.gnt, 0);
    check("rst_err0", m0_if.error, 0);
    cyc(); resetn = 1'b1;
    set_m(0, 0, 0, 0, 0, 0);
    set_s(0, 0, 0);
    smp();
    check("idle_sreq", s_if.req, 0);

    // Single m0 read granted in the same cycle; response next cycle.
    cyc();
    set_m(0, 1, 32'h1000, 0, 0, 4'hF);
    set_s(1, 0, 0);
    smp();
    check("t1_gnt0", m0_if.gnt, 1);
    check("t1_saddr", s_if.addr, 32'h1000);
    check("t1_err1_c0", m1_if.error, 0);
    cyc();
    set_m(0, 0, 0, 0, 0, 0);
    set_s(0, 32'hDEADBEEF, 0);
    smp();
    check("t1_rdata0", m0_if.rdata, 32'hDEADBEEF);
    check("t1_err1_c1", m1_if.error, 0);

    // Simultaneous requests right after reset: m0 first, then m1.
    do_reset(2);
    set_m(0, 1, 32'h0A00, 32'h11, 1, 4'h3);
    set_m(1, 1, 32'h0B00, 32'h22, 1, 4'hC);
    set_s(1, 0, 0);
    smp();
    check("t2_gnt0_c0", m0_if.gnt, 1);
    check("t2_gnt1_c0", m1_if.gnt, 0);
    cyc();
    set_m(0, 1, 32'h0A04, 32'h33, 0, 4'hF);
    smp();
    check("t2_gnt1_c1", m1_if.gnt, 1);
    check("t2_gnt0_c1", m0_if.gnt, 0);
    check("t2_saddr_c1", s_if.addr, 32'h0B00);

    // m1 stalled three cycles holds the port against a later m0 request.
    cyc();
    set_m(0, 0, 0, 0, 0, 0);
    set_m(1, 1, 32'h2000, 32'h44, 1, 4'hF);
    set_s(0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      if (k == 1) set_m(0, 1, 32'h3000, 0, 0, 4'hF);
      if (k == 3) set_s(1, 0, 0);
      smp();
      check($sformatf("t3_saddr_c%0d", k), s_if.addr, 32'h2000);
      check($sformatf("t3_gnt0_c%0d", k), m0_if.gnt, 0);
      check($sformatf("t3_gnt1_c%0d", k), m1_if.gnt, (k == 3) ? 1 : 0);
      cyc();
    end

    // Back-to-back accepts: error returns to m0 while m1 is being accepted.
    set_m(0, 1, 32'h4000, 0, 0, 4'hF);
    set_m(1, 0, 0, 0, 0, 0);
    set_s(1, 0, 0);
    smp();
    check("t4_gnt0_c0", m0_if.gnt, 1);
    cyc();
    set_m(0, 0, 0, 0, 0, 0);
    set_m(1, 1, 32'h5000, 32'h55, 1, 4'h1);
    set_s(1, 32'h12345678, 1);
    smp();
    check("t4_gnt1_c1", m1_if.gnt, 1);
    check("t4_err0_c1", m0_if.error, 1);
    check("t4_err1_c1", m1_if.error, 0);
    cyc();
    set_m(1, 0, 0, 0, 0, 0);
    set_s(0, 0, 0);
    smp();
    check("t4_err1_c2", m1_if.error, 0);
    check("t4_err0_c2", m0_if.error, 0);

    // Reset while m1 holds the lock; afterwards a tie goes to m0.
    cyc();
    set_m(1, 1, 32'h6000, 0, 0, 4'hF);
    set_s(0, 0, 0);
    cyc();
    set_m(0, 1, 32'h7000, 0, 0, 4'hF);
    smp();
    check("t5_locked_addr", s_if.addr, 32'h6000);
    cyc();
    resetn = 1'b0;
    set_s(1, 0, 0);
    for (int k = 0; k < 2; k++) begin
      smp();
      check($sformatf("t5_rst_sreq_%0d", k), s_if.req, 0);
      check($sformatf("t5_rst_gnt1_%0d", k), m1_if.gnt, 0);
      cyc();
    end
    resetn = 1'b1;
    smp();
    check("t5_gnt0", m0_if.gnt, 1);
    check("t5_gnt1", m1_if.gnt, 0);
    check("t5_saddr", s_if.addr, 32'h7000);
    cyc();
    set_m(0, 0, 0, 0, 0, 0);
    smp();
    check("t5_gnt1_next", m1_if.gnt, 1);

    // Random traffic: requesters hold payload until granted, rare drops.
    for (int n = 0; n < 10000; n++) begin
      smp();
      acc[0] = m0_if.req && m0_if.gnt;
      acc[1] = m1_if.req && m1_if.gnt;
      cyc();
      for (int x = 0; x < 2; x++) begin
        bit cur;
        cur = (x == 0) ? m0_if.req : m1_if.req;
        if (!cur || acc[x]) begin
          set_m(x, ($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0, $urandom, $urandom,
                $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)));
        end else if ($urandom_range(0, 99) < 3) begin
          set_m(x, 0, 0, 0, 0, 0);
        end
      end
      set_s($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 20);
    end
    cyc();
    set_m(0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0);
    set_s(0, 0, 0);

    // Fixed priority: m0 keeps requesting and m1 never wins.
    p0_if.req = 1; p0_if.strb = 4'hF;
    p1_if.req = 1; p1_if.addr = 32'h9000; p1_if.strb = 4'hF;
    ps_if.gnt = 1;
    for (int k = 0; k < 8; k++) begin
      p0_if.addr = 32'h8000 + 32'(k * 4);
      smp();
      check($sformatf("fp_gnt0_%0d", k), p0_if.gnt, 1);
      check($sformatf("fp_gnt1_%0d", k), p1_if.gnt, 0);
      check($sformatf("fp_saddr_%0d", k), ps_if.addr, 32'h8000 + 32'(k * 4));
      cyc();
    end
    p0_if.req = 0;
    smp();
    check("fp_gnt1_after", p1_if.gnt, 1);
    check("fp_saddr_after", ps_if.addr, 32'h9000);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
